// File: rtl/alu_operand_stage_if.sv
// Bundle of every non-clock/reset signal of the ALU operand stage.
// slave = the stage itself, master = the environment driving/consuming it.
interface alu_operand_stage_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [XLEN-1:0]  pc_in;
    logic [4:0]       rs1_addr;
    logic [4:0]       rs2_addr;
    logic [XLEN-1:0]  rs1_data;
    logic [XLEN-1:0]  rs2_data;
    logic [XLEN-1:0]  imm;
    logic             a_sel;
    logic             b_sel;
    logic [3:0]       alu_sel_in;
    logic [4:0]       rd_in;
    logic             exm_wen;
    logic [4:0]       exm_rd;
    logic [XLEN-1:0]  exm_data;
    logic             wb_wen;
    logic [4:0]       wb_rd;
    logic [XLEN-1:0]  wb_data;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  op_a;
    logic [XLEN-1:0]  op_b;
    logic [3:0]       alu_sel_out;
    logic [4:0]       rd_out;
    logic [XLEN-1:0]  pc_out;
    logic [CNT_W-1:0] stall_cnt;

    modport slave (
        input  flush, in_valid, pc_in, rs1_addr, rs2_addr, rs1_data, rs2_data,
               imm, a_sel, b_sel, alu_sel_in, rd_in, exm_wen, exm_rd, exm_data,
               wb_wen, wb_rd, wb_data, out_ready,
        output in_ready, out_valid, op_a, op_b, alu_sel_out, rd_out, pc_out, stall_cnt
    );

    modport master (
        output flush, in_valid, pc_in, rs1_addr, rs2_addr, rs1_data, rs2_data,
               imm, a_sel, b_sel, alu_sel_in, rd_in, exm_wen, exm_rd, exm_data,
               wb_wen, wb_rd, wb_data, out_ready,
        input  in_ready, out_valid, op_a, op_b, alu_sel_out, rd_out, pc_out, stall_cnt
    );
endinterface

// File: rtl/alu_operand_stage.sv
// ID/EX register ahead of the ALU: operand select, RAW forwarding, valid/ready, flush, stall count.
// Macro FWD_EN: defined = forward from EX/MEM and MEM/WB; undefined = stall upstream on hazards.
module alu_operand_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input logic                clock,
    input logic                reset,
    alu_operand_stage_if.slave bus
);
    // Handshake: an entry moves on a rising edge where valid && ready are both high;
    // the producer holds its payload stable while valid is high and ready is low.
    logic             out_valid;
    logic [XLEN-1:0]  op_a;
    logic [XLEN-1:0]  op_b;
    logic [3:0]       alu_sel_out;
    logic [4:0]       rd_out;
    logic [XLEN-1:0]  pc_out;
    logic [CNT_W-1:0] stall_cnt;

    logic [XLEN-1:0]  a_next;
    logic [XLEN-1:0]  b_next;
    logic             hazard;
    logic             in_ready;
    logic             xfer;
    logic             backpressure;

`ifdef FWD_EN
    // EX/MEM is the younger producer, so it shadows MEM/WB; x0 is never forwarded.
    always_comb begin
        hazard = 1'b0;
        if (bus.a_sel)
            a_next = bus.pc_in;
        else if (bus.exm_wen && bus.exm_rd == bus.rs1_addr && bus.rs1_addr != 5'd0)
            a_next = bus.exm_data;
        else if (bus.wb_wen && bus.wb_rd == bus.rs1_addr && bus.rs1_addr != 5'd0)
            a_next = bus.wb_data;
        else
            a_next = bus.rs1_data;

        if (bus.b_sel)
            b_next = bus.imm;
        else if (bus.exm_wen && bus.exm_rd == bus.rs2_addr && bus.rs2_addr != 5'd0)
            b_next = bus.exm_data;
        else if (bus.wb_wen && bus.wb_rd == bus.rs2_addr && bus.rs2_addr != 5'd0)
            b_next = bus.wb_data;
        else
            b_next = bus.rs2_data;
    end
`else
    logic a_hit;
    logic b_hit;

    // Without forwarding paths a pending writer of a source register blocks acceptance.
    always_comb begin
        a_next = bus.a_sel ? bus.pc_in : bus.rs1_data;
        b_next = bus.b_sel ? bus.imm   : bus.rs2_data;
        a_hit  = !bus.a_sel && bus.rs1_addr != 5'd0 &&
                 ((bus.exm_wen && bus.exm_rd == bus.rs1_addr) ||
                  (bus.wb_wen  && bus.wb_rd  == bus.rs1_addr));
        b_hit  = !bus.b_sel && bus.rs2_addr != 5'd0 &&
                 ((bus.exm_wen && bus.exm_rd == bus.rs2_addr) ||
                  (bus.wb_wen  && bus.wb_rd  == bus.rs2_addr));
        hazard = bus.in_valid && (a_hit || b_hit);
    end
`endif

    assign in_ready     = (!out_valid || bus.out_ready) && !hazard;
    assign xfer         = bus.in_valid && in_ready;
    assign backpressure = out_valid && !bus.out_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid   <= 1'b0;
            op_a        <= '0;
            op_b        <= '0;
            alu_sel_out <= 4'b0000;
            rd_out      <= '0;
            pc_out      <= '0;
            stall_cnt   <= '0;
        end else begin
            if ((backpressure || hazard) && stall_cnt != {CNT_W{1'b1}})
                stall_cnt <= stall_cnt + CNT_W'(1);

            if (bus.flush) begin
                out_valid <= 1'b0;
            end else if (xfer) begin
                out_valid   <= 1'b1;
                op_a        <= a_next;
                op_b        <= b_next;
                alu_sel_out <= bus.alu_sel_in;
                rd_out      <= bus.rd_in;
                pc_out      <= bus.pc_in;
            end else if (bus.out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid;
    assign bus.op_a        = op_a;
    assign bus.op_b        = op_b;
    assign bus.alu_sel_out = alu_sel_out;
    assign bus.rd_out      = rd_out;
    assign bus.pc_out      = pc_out;
    assign bus.stall_cnt   = stall_cnt;
endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage; covers both FWD_EN builds.
module tb_alu_operand_stage;
    localparam int XLEN  = 32;
    localparam int CNT_W = 16;
    localparam int W     = 2 * XLEN + 4 + 5 + XLEN;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic rand_bp = 1'b0;
    int   total = 0;
    int   bad   = 0;
    logic [W-1:0] exp_q[$];

    alu_operand_stage_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

    alu_operand_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    // clock / reset
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        bus.flush = 0; bus.in_valid = 0; bus.pc_in = 0; bus.rs1_addr = 0; bus.rs2_addr = 0;
        bus.rs1_data = 0; bus.rs2_data = 0; bus.imm = 0; bus.a_sel = 0; bus.b_sel = 0;
        bus.alu_sel_in = 0; bus.rd_in = 0; bus.exm_wen = 0; bus.exm_rd = 0; bus.exm_data = 0;
        bus.wb_wen = 0; bus.wb_rd = 0; bus.wb_data = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        exp_q.delete();
    endtask

    function automatic logic [XLEN-1:0] model_op(input logic sel, input logic [XLEN-1:0] alt,
                                                 input logic [4:0] addr, input logic [XLEN-1:0] data);
        if (sel) return alt;
`ifdef FWD_EN
        if (bus.exm_wen && bus.exm_rd == addr && addr != 5'd0) return bus.exm_data;
        if (bus.wb_wen && bus.wb_rd == addr && addr != 5'd0) return bus.wb_data;
`endif
        return data;
    endfunction

    // driver: presents one entry, records the expected output at the transfer edge
    task automatic send(input logic [XLEN-1:0] pc, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d2,
                        input logic [XLEN-1:0] imm, input logic as, input logic bs,
                        input logic [3:0] op, input logic [4:0] rd);
        logic accepted;
        bus.pc_in = pc; bus.rs1_addr = r1; bus.rs2_addr = r2; bus.rs1_data = d1; bus.rs2_data = d2;
        bus.imm = imm; bus.a_sel = as; bus.b_sel = bs; bus.alu_sel_in = op; bus.rd_in = rd;
        bus.in_valid = 1'b1;
        accepted = 1'b0;
        for (int i = 0; i < 30 && !accepted; i++) begin
            @(negedge clock);
            if (bus.in_ready && !bus.flush) begin
                exp_q.push_back({model_op(as, pc, r1, d1), model_op(bs, imm, r2, d2), op, rd, pc});
                accepted = 1'b1;
            end
            @(posedge clock);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!accepted) chk("send_timeout", 0, 1);
    endtask

    // scoreboard: an entry leaves when out_valid && out_ready at the coming edge; flush kills it
    always @(negedge clock) begin
        if (!reset && bus.out_valid && (bus.out_ready || bus.flush)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", 1, 0);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if (!bus.flush)
                    chk("out_entry", {bus.op_a, bus.op_b, bus.alu_sel_out, bus.rd_out, bus.pc_out}, e);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (rand_bp) bus.out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        bus.out_ready = 1'b1;
        clear_inputs();
        #2;
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_op_a", bus.op_a, 0);
        chk("rst_op_b", bus.op_b, 0);
        chk("rst_alu_sel", bus.alu_sel_out, 0);
        chk("rst_rd", bus.rd_out, 0);
        chk("rst_pc", bus.pc_out, 0);
        chk("rst_stall", bus.stall_cnt, 0);
        do_reset();

        // single transfer, 1-cycle latency, then drain
        @(posedge clock); #1;
        send(32'h40, 5'd1, 5'd2, 32'd5, 32'd3, 32'd0, 1'b0, 1'b0, 4'b0001, 5'd9);
        chk("single_valid", bus.out_valid, 1);
        chk("single_op_a", bus.op_a, 5);
        chk("single_op_b", bus.op_b, 3);
        chk("single_alu", bus.alu_sel_out, 4'b0001);
        @(posedge clock); #1;
        chk("single_drain", bus.out_valid, 0);

`ifdef FWD_EN
        bus.exm_wen = 1; bus.exm_rd = 7; bus.exm_data = 32'h11;
        bus.wb_wen = 1; bus.wb_rd = 7; bus.wb_data = 32'h22;
        send(32'h44, 5'd7, 5'd3, 32'h99, 32'h1, 32'd0, 1'b0, 1'b0, 4'b0010, 5'd1);
        chk("fwd_exm_prio", bus.op_a, 32'h11);
        bus.exm_wen = 0;
        send(32'h48, 5'd7, 5'd3, 32'h99, 32'h1, 32'd0, 1'b0, 1'b0, 4'b0011, 5'd1);
        chk("fwd_wb", bus.op_a, 32'h22);
        bus.wb_rd = 3;
        send(32'h4c, 5'd1, 5'd3, 32'h77, 32'h1, 32'd0, 1'b0, 1'b0, 4'b0100, 5'd2);
        chk("fwd_wb_b", bus.op_b, 32'h22);
        bus.wb_wen = 0;
`else
        do_reset();
        @(posedge clock); #1;
        bus.rs1_addr = 7; bus.a_sel = 0; bus.b_sel = 1; bus.exm_wen = 1; bus.exm_rd = 7;
        bus.in_valid = 1;
        @(negedge clock); chk("haz_ready0", bus.in_ready, 0);
        @(posedge clock); #1;
        @(negedge clock); chk("haz_ready1", bus.in_ready, 0);
        @(posedge clock); #1;
        chk("haz_stall2", bus.stall_cnt, 2);
        bus.exm_wen = 0; bus.wb_wen = 1; bus.wb_rd = 7;
        @(negedge clock); chk("haz_wb_ready", bus.in_ready, 0);
        @(posedge clock); #1;
        chk("haz_stall3", bus.stall_cnt, 3);
        bus.wb_wen = 0;
        send(32'h50, 5'd7, 5'd0, 32'h55, 32'h0, 32'h8, 1'b0, 1'b1, 4'b0110, 5'd7);
        chk("haz_release_a", bus.op_a, 32'h55);
        chk("haz_stall_keep", bus.stall_cnt, 3);
        bus.rs1_addr = 3; bus.rs2_addr = 4; bus.a_sel = 0; bus.b_sel = 0;
        bus.exm_wen = 1; bus.exm_rd = 3; bus.wb_wen = 1; bus.wb_rd = 4; bus.in_valid = 1;
        @(posedge clock); #1;
        chk("haz_both_once", bus.stall_cnt, 4);
        bus.in_valid = 0; bus.exm_wen = 0; bus.wb_wen = 0;
`endif

        // x0 is never a hazard/forward source
        bus.exm_wen = 1; bus.exm_rd = 0; bus.exm_data = 32'hDEAD;
        send(32'h60, 5'd1, 5'd0, 32'h12, 32'h0, 32'd0, 1'b0, 1'b0, 4'b0000, 5'd4);
        chk("x0_guard", bus.op_b, 0);
        send(32'h64, 5'd0, 5'd0, 32'h34, 32'h56, 32'd0, 1'b0, 1'b0, 4'b0001, 5'd4);
        chk("x0_guard_data", bus.op_a, 32'h34);

        // PC / immediate select override a live forward
        bus.exm_rd = 5; bus.exm_data = 32'hBAD;
        send(32'h100, 5'd5, 5'd5, 32'h1, 32'h2, 32'hFFFFFFFC, 1'b1, 1'b1, 4'b0111, 5'd6);
        chk("sel_pc", bus.op_a, 32'h100);
        chk("sel_imm", bus.op_b, 32'hFFFFFFFC);
        bus.exm_wen = 0;

        // random traffic with random backpressure, high opcodes included
        rand_bp = 1'b1;
        for (int i = 0; i < 40; i++) begin
            send($urandom, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), $urandom, $urandom,
                 $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 (i < 6) ? 4'(10 + i) : 4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)));
        end
        rand_bp = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clock);
        #1 chk("rand_drained", exp_q.size(), 0);

        // backpressure hold then flush with a same-cycle incoming entry
        do_reset();
        bus.out_ready = 1'b0;
        @(posedge clock); #1;
        send(32'h200, 5'd1, 5'd2, 32'hA5A5, 32'h5A5A, 32'd0, 1'b0, 1'b0, 4'b1010, 5'd3);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("hold_valid", bus.out_valid, 1);
            chk("hold_ready", bus.in_ready, 0);
            chk("hold_data", {bus.op_a, bus.op_b, bus.alu_sel_out, bus.rd_out, bus.pc_out}, exp_q[0]);
            @(posedge clock); #1;
        end
        chk("hold_stall4", bus.stall_cnt, 4);
        bus.flush = 1; bus.out_ready = 1; bus.in_valid = 1; bus.alu_sel_in = 4'b1111;
        @(posedge clock); #1;
        bus.flush = 0; bus.in_valid = 0;
        chk("flush_valid", bus.out_valid, 0);
        @(posedge clock); #1;
        chk("flush_no_entry", bus.out_valid, 0);
        chk("flush_q_empty", exp_q.size(), 0);

        // async reset between edges while holding
        bus.out_ready = 1'b0;
        send(32'h300, 5'd1, 5'd2, 32'h1, 32'h2, 32'd0, 1'b0, 1'b0, 4'b1100, 5'd8);
        repeat (2) begin @(posedge clock); #1; end
        @(negedge clock); #1;
        chk("pre_areset_valid", bus.out_valid, 1);
        reset = 1'b1;
        #1;
        chk("areset_valid", bus.out_valid, 0);
        chk("areset_stall", bus.stall_cnt, 0);
        chk("areset_alu", bus.alu_sel_out, 0);
        exp_q.delete();
        #1 reset = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- ID/EX pipeline register sitting directly upstream of the ALU.
- Captures a decoded instruction's operands and resolves RAW hazards by forwarding from the EX/MEM and MEM/WB stages.
- Selects the PC or immediate operand where the instruction needs it.
- Presents registered op_a, op_b and alu_sel to the ALU under a valid/ready handshake, with flush support and a stall counter.

Parameters:
- XLEN, 32, data width of operands, PC and forwarded results.
- CNT_W, 16, width of the stall counter.

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high reset
- flush  in  1  kill the held entry and any same-cycle incoming entry
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept an entry this cycle
- pc_in  in  XLEN  instruction PC
- rs1_addr, rs2_addr  in  5 each  source register indices
- rs1_data, rs2_data  in  XLEN each  register-file read data
- imm  in  XLEN  decoded immediate
- a_sel  in  1  0 = rs1, 1 = PC
- b_sel  in  1  0 = rs2, 1 = imm
- alu_sel_in  in  4  ALU operation code
- rd_in  in  5  destination index
- exm_wen, exm_rd, exm_data  in  1 / 5 / XLEN  EX/MEM writeback candidate
- wb_wen, wb_rd, wb_data  in  1 / 5 / XLEN  MEM/WB writeback candidate
- out_valid  out  1  held entry valid
- out_ready  in  1  ALU stage accepts the held entry
- op_a, op_b  out  XLEN each  ALU operands
- alu_sel_out  out  4  ALU operation code
- rd_out  out  5  destination index
- pc_out  out  XLEN  instruction PC
- stall_cnt  out  CNT_W  saturating count of backpressure cycles

Behaviour:
- Reset (async, active-high):
  - out_valid = 0.
  - op_a, op_b, pc_out, rd_out and stall_cnt = 0.
  - alu_sel_out = 4'b0000 (add).
  - Takes effect immediately. Any mid-transfer entry is discarded.
- Accept:
  - in_ready = !out_valid || out_ready (with FWD_EN).
  - Transfer when in_valid && in_ready. All output registers load on that edge, so latency is 1 cycle.
- Hold: when out_valid && !out_ready, every output register stays bit-stable.
- Drain: out_valid && out_ready && !(in_valid && in_ready) clears out_valid. Data registers keep their last value.
- Flush (highest priority after reset):
  - Next edge: out_valid = 0.
  - An incoming entry in the same cycle is dropped, not loaded.
  - Data registers are don't-care. in_ready is unaffected by flush.
- Operand A resolution:
  - a_sel = 1: pc_in.
  - Else exm_data if exm_wen && exm_rd == rs1_addr && rs1_addr != 0.
  - Else wb_data if wb_wen && wb_rd == rs1_addr && rs1_addr != 0.
  - Else rs1_data.
- Operand B resolution: same chain with b_sel / imm / rs2_addr / rs2_data.
- Forwarding priority and x0:
  - EX/MEM wins over MEM/WB.
  - x0 is never forwarded, so a register operand sourced from x0 takes rs1_data/rs2_data as supplied.
- Forwarding is sampled only in the transfer cycle. A held entry never re-resolves.
- alu_sel_in passes unmodified, including codes 4'b1010–4'b1111.
- stall_cnt:
  - Increments by 1 on each edge where out_valid && !out_ready.
  - Saturates at all-ones. Clears only on reset.

Optional Feature:
- Macro: FWD_EN.
- Defined: forwarding as above.
- Undefined:
  - Forwarding paths are absent and the register-sourced operand is always rs1_data/rs2_data.
  - A hazard holds the upstream entry, with in_ready = (!out_valid || out_ready) && !hazard.
  - hazard = in_valid && ((a_sel = 0 and rs1_addr != 0 and rs1_addr matches exm_rd or wb_rd with the corresponding wen set) or the same condition with b_sel = 0 and rs2_addr).
  - stall_cnt additionally increments on hazard cycles, once per cycle even if both conditions hold.

Test Plan:
- Reset then single transfer:
  - Stimulus: rs1_data = 5, rs2_data = 3, a_sel = 0, b_sel = 0, alu_sel_in = 0001, in_valid for 1 cycle, out_ready = 1.
  - Response: one cycle later out_valid = 1, op_a = 5, op_b = 3, alu_sel_out = 0001. The following cycle out_valid = 0.
- Forward priority:
  - Stimulus: rs1_addr = 7, exm_wen = 1, exm_rd = 7, exm_data = 0x11, wb_wen = 1, wb_rd = 7, wb_data = 0x22.
  - Response: op_a = 0x11. With exm_wen = 0: op_a = 0x22.
- x0 guard:
  - Stimulus: rs2_addr = 0, exm_wen = 1, exm_rd = 0, exm_data = 0xDEAD, rs2_data = 0.
  - Response: op_b = 0.
- Immediate/PC select:
  - Stimulus: a_sel = 1, b_sel = 1, pc_in = 0x100, imm = 0xFFFFFFFC, with a matching exm forward active.
  - Response: op_a = 0x100, op_b = 0xFFFFFFFC.
- Backpressure and flush:
  - Stimulus: out_ready = 0 for 4 cycles after a load, then flush = 1 together with in_valid = 1.
  - Response: outputs stable, stall_cnt = 4, in_ready = 0 during the hold. After flush: out_valid = 0, no new entry.
- Async reset mid-hold:
  - Stimulus: assert reset between clock edges with out_valid = 1.
  - Response: out_valid = 0, stall_cnt = 0 and alu_sel_out = 0000 immediately, before the next edge.
